// File: rtl/vga_capture.sv
// vga_capture: receive side of the VGA pixel path.
// Rebuilds the h/v pixel counters from the falling edges of the active-low syncs.
// Writes every pixel inside the inclusive margin window to a frame buffer at sequential addresses.
// Optional feature macro: VGA_CAPTURE_CHECKSUM_EN adds a per-frame 16-bit pixel sum on Checksum.
module vga_capture #(
    parameter int unsigned DATA_WIDTH      = 12,
    parameter int unsigned COLOR_WIDTH     = 4,
    parameter int unsigned REZ_MAX_WIDTH   = 11,
    parameter int unsigned HL_MARGIN_WIDTH = 11,
    parameter int unsigned HR_MARGIN_WIDTH = 11,
    parameter int unsigned VL_MARGIN_WIDTH = 11,
    parameter int unsigned VR_MARGIN_WIDTH = 11,
    parameter int unsigned ADDR_WIDTH      = 19
) (
    input  logic                       Clk,
    input  logic                       Rst,
    input  logic                       Pixel_en,
    input  logic                       Enable,
    input  logic                       Hsync,
    input  logic                       Vsync,
    input  logic [COLOR_WIDTH-1:0]     Red,
    input  logic [COLOR_WIDTH-1:0]     Green,
    input  logic [COLOR_WIDTH-1:0]     Blue,
    input  logic [HL_MARGIN_WIDTH-1:0] H_left_margin,
    input  logic [HR_MARGIN_WIDTH-1:0] H_right_margin,
    input  logic [VL_MARGIN_WIDTH-1:0] V_left_margin,
    input  logic [VR_MARGIN_WIDTH-1:0] V_right_margin,
    output logic                       Wr_en,
    output logic [ADDR_WIDTH-1:0]      Wr_addr,
    output logic [DATA_WIDTH-1:0]      Wr_data,
    output logic                       Frame_done,
    output logic                       Busy,
    output logic                       Line_err,
    output logic [7:0]                 Frame_cnt
`ifdef VGA_CAPTURE_CHECKSUM_EN
    ,
    output logic [15:0]                Checksum
`endif
);

    // Line counter is one bit wider than the pixel counters so a full-width line length fits.
    localparam int unsigned LINE_W = REZ_MAX_WIDTH + 1;
    localparam int unsigned CMP_W  = 32;
    localparam int unsigned SUM_W  = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic                     hs_prev_q, hs_prev_d;
    logic                     vs_prev_q, vs_prev_d;
    logic [REZ_MAX_WIDTH-1:0] count_h_q, count_h_d;
    logic [REZ_MAX_WIDTH-1:0] count_v_q, count_v_d;
    logic [ADDR_WIDTH-1:0]    addr_cnt_q, addr_cnt_d;
    logic [LINE_W-1:0]        line_cnt_q, line_cnt_d;
    logic                     wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0]    wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0]    wr_data_q, wr_data_d;
    logic                     frame_done_q, frame_done_d;
    logic                     busy_q, busy_d;
    logic                     line_err_q, line_err_d;
    logic [7:0]               frame_cnt_q, frame_cnt_d;
`ifdef VGA_CAPTURE_CHECKSUM_EN
    logic [SUM_W-1:0]         acc_q, acc_d;
    logic [SUM_W-1:0]         checksum_q, checksum_d;
`endif

    logic                     hs_edge;
    logic                     vs_edge;
    logic                     any_edge;
    logic                     in_window;
    logic                     pix_active;
    logic [LINE_W-1:0]        expected_len;
    logic                     line_bad;
    logic [DATA_WIDTH-1:0]    pixel_word;

    // Sync edge detection, window test and line-length comparison.
    always_comb begin
        hs_edge      = Pixel_en & hs_prev_q & ~Hsync;
        vs_edge      = Pixel_en & vs_prev_q & ~Vsync;
        any_edge     = hs_edge | vs_edge;
        in_window    = (CMP_W'(count_h_q) >= CMP_W'(H_left_margin))  &&
                       (CMP_W'(count_h_q) <= CMP_W'(H_right_margin)) &&
                       (CMP_W'(count_v_q) >= CMP_W'(V_left_margin))  &&
                       (CMP_W'(count_v_q) <= CMP_W'(V_right_margin));
        pix_active   = Pixel_en & ~any_edge & in_window;
        expected_len = LINE_W'(H_right_margin) - LINE_W'(H_left_margin) + LINE_W'(1);
        line_bad     = (line_cnt_q != '0) && (line_cnt_q != expected_len);
        pixel_word   = DATA_WIDTH'({Blue, Green, Red});
    end

    // Sync history and h/v counter rebuild; Vsync wins over a simultaneous Hsync edge.
    always_comb begin
        hs_prev_d = hs_prev_q;
        vs_prev_d = vs_prev_q;
        count_h_d = count_h_q;
        count_v_d = count_v_q;
        if (Pixel_en) begin
            hs_prev_d = Hsync;
            vs_prev_d = Vsync;
            if (vs_edge) begin
                count_h_d = '0;
                count_v_d = '0;
            end else if (hs_edge) begin
                count_h_d = '0;
                count_v_d = count_v_q + REZ_MAX_WIDTH'(1);
            end else begin
                count_h_d = count_h_q + REZ_MAX_WIDTH'(1);
            end
        end
    end

    // Capture FSM: next state, write staging, frame and line bookkeeping.
    always_comb begin
        state_d      = state_q;
        addr_cnt_d   = addr_cnt_q;
        line_cnt_d   = line_cnt_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        frame_done_d = 1'b0;
        line_err_d   = line_err_q;
        frame_cnt_d  = frame_cnt_q;
`ifdef VGA_CAPTURE_CHECKSUM_EN
        acc_d        = acc_q;
        checksum_d   = checksum_q;
`endif
        if (any_edge) begin
            line_cnt_d = '0;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (Enable) begin
                    state_d = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (!Enable) begin
                    state_d = ST_IDLE;
                end else if (vs_edge) begin
                    state_d    = ST_CAPTURE;
                    addr_cnt_d = '0;
                    line_cnt_d = '0;
                    line_err_d = 1'b0;
`ifdef VGA_CAPTURE_CHECKSUM_EN
                    acc_d      = '0;
`endif
                end
            end
            ST_CAPTURE: begin
                if (vs_edge) begin
                    // End of frame; the same edge starts the next frame when still enabled.
                    frame_done_d = 1'b1;
                    frame_cnt_d  = frame_cnt_q + 8'd1;
                    addr_cnt_d   = '0;
                    if (line_bad) begin
                        line_err_d = 1'b1;
                    end
`ifdef VGA_CAPTURE_CHECKSUM_EN
                    checksum_d   = acc_q;
                    acc_d        = '0;
`endif
                    if (!Enable) begin
                        state_d = ST_IDLE;
                    end
                end else if (hs_edge) begin
                    if (line_bad) begin
                        line_err_d = 1'b1;
                    end
                end else if (pix_active) begin
                    wr_en_d    = 1'b1;
                    wr_addr_d  = addr_cnt_q;
                    wr_data_d  = pixel_word;
                    addr_cnt_d = addr_cnt_q + ADDR_WIDTH'(1);
                    line_cnt_d = line_cnt_q + LINE_W'(1);
`ifdef VGA_CAPTURE_CHECKSUM_EN
                    acc_d      = acc_q + SUM_W'(pixel_word);
`endif
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q      <= ST_IDLE;
            hs_prev_q    <= 1'b1;
            vs_prev_q    <= 1'b1;
            count_h_q    <= '0;
            count_v_q    <= '0;
            addr_cnt_q   <= '0;
            line_cnt_q   <= '0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
            line_err_q   <= 1'b0;
            frame_cnt_q  <= '0;
`ifdef VGA_CAPTURE_CHECKSUM_EN
            acc_q        <= '0;
            checksum_q   <= '0;
`endif
        end else begin
            state_q      <= state_d;
            hs_prev_q    <= hs_prev_d;
            vs_prev_q    <= vs_prev_d;
            count_h_q    <= count_h_d;
            count_v_q    <= count_v_d;
            addr_cnt_q   <= addr_cnt_d;
            line_cnt_q   <= line_cnt_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            frame_done_q <= frame_done_d;
            busy_q       <= busy_d;
            line_err_q   <= line_err_d;
            frame_cnt_q  <= frame_cnt_d;
`ifdef VGA_CAPTURE_CHECKSUM_EN
            acc_q        <= acc_d;
            checksum_q   <= checksum_d;
`endif
        end
    end

    assign Wr_en      = wr_en_q;
    assign Wr_addr    = wr_addr_q;
    assign Wr_data    = wr_data_q;
    assign Frame_done = frame_done_q;
    assign Busy       = busy_q;
    assign Line_err   = line_err_q;
    assign Frame_cnt  = frame_cnt_q;
`ifdef VGA_CAPTURE_CHECKSUM_EN
    assign Checksum   = checksum_q;
`endif

endmodule

// File: doc/vga_capture.md
# vga_capture

- Receive-side counterpart of the VGA pixel output path.
- Samples a 4:4:4 RGB stream plus active-low Hsync/Vsync, rebuilds the horizontal and vertical pixel counters from sync edges, and selects the display window with inclusive margins, using the same rule as the display side.
- Packs each in-window pixel into a 12-bit word and writes it to a frame buffer with a sequential address.
- Used for loopback self-test and for capturing frames from external VGA sources.

## Interface
- DATA_WIDTH, 12, packed pixel word width.
- COLOR_WIDTH, 4, width of each colour channel.
- REZ_MAX_WIDTH, 11, width of the rebuilt h/v counters.
- HL_MARGIN_WIDTH / HR_MARGIN_WIDTH / VL_MARGIN_WIDTH / VR_MARGIN_WIDTH, 11, widths of the window margins.
- ADDR_WIDTH, 19, frame-buffer write address width.
- Clk  in  1  system clock; one clock only, all logic on the rising edge.
- Rst  in  1  synchronous, active-high reset.
- Pixel_en  in  1  pixel strobe; all video inputs are qualified by it.
- Enable  in  1  level; arms or keeps continuous capture.
- Hsync, Vsync  in  1 each  active-low syncs.
- Red, Green, Blue  in  COLOR_WIDTH each  pixel colour.
- H_left_margin, H_right_margin, V_left_margin, V_right_margin  in  margin widths  inclusive window bounds.
- Wr_en  out  1  write strobe.
- Wr_addr  out  ADDR_WIDTH  write address.
- Wr_data  out  DATA_WIDTH  packed pixel {Blue, Green, Red}: Red in [3:0], Green in [7:4], Blue in [11:8].
- Frame_done  out  1  one-cycle pulse at the end of a captured frame.
- Busy  out  1  high in ARMED or CAPTURE.
- Line_err  out  1  sticky line-length mismatch flag.
- Frame_cnt  out  8  count of completed frames.
- Checksum  out  16  per-frame pixel sum; present only with the macro (see Configuration).

## Operation
**Sync and counters**
- Hsync and Vsync are registered on each Pixel_en cycle.
- A falling edge is (previous sample high) and (current input low), evaluated only on Pixel_en cycles.
- Hsync edge: Count_h <= 0 and Count_v <= Count_v + 1.
- Vsync edge: Count_h <= 0 and Count_v <= 0. Vsync has priority when both edges occur in the same cycle.
- Pixel_en cycle with no edge: the pixel is evaluated against the current Count_h/Count_v, then Count_h increments.
- An edge cycle's pixel is never captured.
- Counters wrap at 2^REZ_MAX_WIDTH.

**Active window**
- A pixel is active when all of these hold: Count_h >= H_left_margin, Count_h <= H_right_margin, Count_v >= V_left_margin, Count_v <= V_right_margin.
- If a left margin is greater than its right margin, no pixel is ever active.

**State machine**
- IDLE -> ARMED when Enable = 1.
- ARMED -> CAPTURE on a Vsync edge; the address clears to 0 and the line counter clears.
- In CAPTURE, each active pixel produces one write and Wr_addr increments.
- A Vsync edge in CAPTURE ends the frame: Frame_done pulses and Frame_cnt increments (wraps at 255).
- After that edge: Enable = 1 -> stay in CAPTURE with the address reset to 0. Enable = 0 -> IDLE.
- Enable going low mid-frame does not abort the frame; the block returns to IDLE at the next Vsync edge.
- ARMED -> IDLE when Enable = 0.
- Wr_addr wraps at 2^ADDR_WIDTH without a flag.

**Line check**
- Expected line length = H_right_margin - H_left_margin + 1.
- On each Hsync or Vsync edge in CAPTURE, if the line's captured count is nonzero and differs from the expected length, Line_err is set.
- The line counter clears on every edge.
- Line_err clears only on Rst or on the ARMED -> CAPTURE transition.

## Timing
- Reset values: all outputs 0, state IDLE, counters 0.
- Sync history registers reset high, so there is no false edge after reset.
- Wr_en, Wr_addr and Wr_data are registered: they are valid exactly one cycle after the Pixel_en cycle that sampled the active pixel.
- Wr_en lasts one cycle per pixel; the first write of a frame has Wr_addr = 0.
- Frame_done is asserted the cycle after the Vsync edge cycle.
- Frame_cnt updates in that same cycle.
- Line_err rises the cycle after the offending edge.
- Rst asserted mid-frame: IDLE on the next cycle. No Frame_done is produced and any write staged for that cycle is dropped.

## Configuration
- Macro: VGA_CAPTURE_CHECKSUM_EN.
- Defined:
  - A 16-bit accumulator adds the zero-extended Wr_data of every write, modulo 2^16.
  - It clears at the start of each frame.
  - Its value is latched to Checksum in the same cycle as Frame_done.
- Undefined: the Checksum port and the accumulator are absent.

## Test plan
- Margins H 2..5, V 1..2, Enable = 1, Pixel_en = 1, constant RGB R=1 G=2 B=3 -> after a Vsync edge, 8 writes per frame with Wr_addr 0..7 and Wr_data 12'h321, then Frame_done with Frame_cnt = 1.
- Same margins, Enable dropped during frame 2 -> frame 2 completes all 8 writes, Frame_done pulses, Busy = 0; no writes in frame 3.
- Hsync and Vsync falling edges in the same cycle -> Count_v = 0, not 1; the next frame starts at Wr_addr 0.
- One line shortened to 3 active pixels -> Line_err = 1 the cycle after that line's edge, held through Frame_done, cleared on re-arm.
- Pixel_en toggling 1/0, with inputs changing while Pixel_en = 0 -> writes identical to the full-rate run; non-strobe values are ignored.
- With VGA_CAPTURE_CHECKSUM_EN, Wr_data 12'hFFF on 20 active pixels -> Checksum = 16'h3FEC.
